// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and request classification helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        S_IDLE,
        S_RMW
    } lsu_state_e;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (f3[1:0])
            F3_H[1:0]: bad = addr_lo[0];
            F3_W[1:0]: bad = (addr_lo != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_data_port_if.sv
// Request/response handshake plus word-wide memory port of the LSU.
// master = the LSU (initiator on memory), slave = core pipeline and memory.
interface lsu_data_port_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] data_addr;
    logic [31:0] write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] read_data;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, read_data,
        output req_ready, resp_valid, resp_data, resp_err,
               data_addr, write_data, MemRead, MemWrite
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, read_data,
        input  req_ready, resp_valid, resp_data, resp_err,
               data_addr, write_data, MemRead, MemWrite
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane steering: load extract+extend (i_merge=0) or store merge
// of i_wdata into i_word (i_merge=1), selected by funct3 and addr[1:0].
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        i_merge,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;
    logic [31:0] w_extract;
    logic [31:0] w_merged;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        w_sext = !i_funct3[2];

        w_extract = i_word;
        w_merged  = i_word;
        case (i_funct3[1:0])
            F3_B[1:0]: begin
                w_extract = {{24{w_sext & w_byte[7]}}, w_byte};
                w_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            F3_H[1:0]: begin
                w_extract = {{16{w_sext & w_half[15]}}, w_half};
                w_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                w_extract = i_word;
                w_merged  = i_wdata;
            end
        endcase

        o_data = i_merge ? w_merged : w_extract;
    end

endmodule

// File: rtl/lsu_data_port.sv
// MEM-stage load/store unit: word-aligned memory cycles, sub-word stores as a
// two-cycle read-modify-write, registered one-cycle response.
module lsu_data_port
    import lsu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    lsu_data_port_if.master   bus
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic [31:0] r_merge;
    logic [31:0] r_addr;

    logic        w_accept;
    logic        w_err;
    logic        w_sub_store;
    logic [31:0] w_word_addr;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;
    logic        w_ready;
    logic        w_mem_read;
    logic        w_mem_write;
    logic [31:0] w_data_addr;
    logic [31:0] w_write_data;

    assign w_err       = !f3_legal(bus.req_is_store, bus.req_funct3)
                       || misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign w_accept    = bus.req_valid && (r_state == S_IDLE);
    assign w_sub_store = bus.req_is_store && (bus.req_funct3[1:0] != F3_W[1:0]);
    assign w_word_addr = {bus.req_addr[31:2], 2'b00};

    lsu_lane_align u_load_align (
        .i_merge   (1'b0),
        .i_funct3  (bus.req_funct3),
        .i_addr_lo (bus.req_addr[1:0]),
        .i_word    (bus.read_data),
        .i_wdata   ('0),
        .o_data    (w_load_data)
    );

    lsu_lane_align u_merge_align (
        .i_merge   (1'b1),
        .i_funct3  (bus.req_funct3),
        .i_addr_lo (bus.req_addr[1:0]),
        .i_word    (bus.read_data),
        .i_wdata   (bus.req_wdata),
        .o_data    (w_merge_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_err && w_sub_store) w_state_nxt = S_RMW;
            S_RMW:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Error requests leave the memory port completely quiet, address included.
    always_comb begin
        w_ready      = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_data_addr  = '0;
        w_write_data = '0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid && !w_err) begin
                    w_data_addr = w_word_addr;
                    if (!bus.req_is_store || w_sub_store) begin
                        w_mem_read = 1'b1;
                    end else begin
                        w_mem_write  = 1'b1;
                        w_write_data = bus.req_wdata;
                    end
                end
            end
            S_RMW: begin
                w_mem_write  = 1'b1;
                w_data_addr  = r_addr;
                w_write_data = r_merge;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_merge      <= '0;
            r_addr       <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            if (r_state == S_RMW) begin
                r_resp_valid <= 1'b1;
            end else if (w_accept) begin
                if (w_err) begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b1;
                end else if (!bus.req_is_store) begin
                    r_resp_valid <= 1'b1;
                    r_resp_data  <= w_load_data;
                end else if (!w_sub_store) begin
                    r_resp_valid <= 1'b1;
                end else begin
                    r_merge <= w_merge_data;
                    r_addr  <= w_word_addr;
                end
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.MemRead    = w_mem_read;
    assign bus.MemWrite   = w_mem_write;
    assign bus.data_addr  = w_data_addr;
    assign bus.write_data = w_write_data;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_data_port.sv
// Directed self-checking bench for lsu_data_port with a small word memory.
module tb_lsu_data_port;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic seed;
    int   checks = 0;
    int   errors = 0;

    lsu_data_port_if bus ();

    lsu_data_port dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign bus.read_data = mem[bus.data_addr[9:2]];

    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[64] <= 32'h8899AABB;
        end else if (bus.MemWrite) begin
            mem[bus.data_addr[9:2]] <= bus.write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w);
        bus.req_valid    = v;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = w;
    endtask

    task automatic load_op(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        req(1'b1, 1'b0, f3, a, 32'h0);
        #1;
        check({tag, "_memread"}, {31'b0, bus.MemRead}, 32'd1);
        check({tag, "_memwrite"}, {31'b0, bus.MemWrite}, 32'd0);
        check({tag, "_addr"}, bus.data_addr, {a[31:2], 2'b00});
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
        check({tag, "_data"}, bus.resp_data, exp);
        check({tag, "_err"}, {31'b0, bus.resp_err}, 32'd0);
    endtask

    task automatic err_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
        @(negedge clk);
        req(1'b1, st, f3, a, 32'hFFFF_FFFF);
        #1;
        check({tag, "_memread"}, {31'b0, bus.MemRead}, 32'd0);
        check({tag, "_memwrite"}, {31'b0, bus.MemWrite}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
        check({tag, "_err"}, {31'b0, bus.resp_err}, 32'd1);
        check({tag, "_data"}, bus.resp_data, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        seed  = 1'b1;
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        seed = 1'b0;
        #1;
        check("rst_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_data", bus.resp_data, 32'h0);
        check("rst_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
        check("rst_memread", {31'b0, bus.MemRead}, 32'd0);
        check("rst_memwrite", {31'b0, bus.MemWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Loads back-to-back from the seeded word 0x8899AABB
        load_op("lb103", F3_B, 32'h103, 32'hFFFF_FF88);
        load_op("lhu102", F3_HU, 32'h102, 32'h0000_8899);
        load_op("lh102", F3_H, 32'h102, 32'hFFFF_8899);
        load_op("lbu100", F3_BU, 32'h100, 32'h0000_00BB);
        @(negedge clk);
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check("idle_memread", {31'b0, bus.MemRead}, 32'd0);
        check("idle_addr", bus.data_addr, 32'h0);
        check("idle_wdata", bus.write_data, 32'h0);
        @(posedge clk);
        #1;
        check("idle_valid", {31'b0, bus.resp_valid}, 32'd0);

        // SB 0x101 read-modify-write, with an LW waiting during RMW
        @(negedge clk);
        req(1'b1, 1'b1, F3_B, 32'h101, 32'h1234_5677);
        #1;
        check("sb_rd_memread", {31'b0, bus.MemRead}, 32'd1);
        check("sb_rd_memwrite", {31'b0, bus.MemWrite}, 32'd0);
        check("sb_rd_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("sb_rd_valid", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        req(1'b1, 1'b0, F3_W, 32'h100, 32'h0);
        #1;
        check("rmw_ready", {31'b0, bus.req_ready}, 32'd0);
        check("rmw_memread", {31'b0, bus.MemRead}, 32'd0);
        check("rmw_memwrite", {31'b0, bus.MemWrite}, 32'd1);
        check("rmw_wdata", bus.write_data, 32'h8899_77BB);
        check("rmw_addr", bus.data_addr, 32'h100);
        @(posedge clk);
        #1;
        check("sb_valid", {31'b0, bus.resp_valid}, 32'd1);
        check("sb_data", bus.resp_data, 32'h0);
        check("sb_err", {31'b0, bus.resp_err}, 32'd0);
        check("sb_mem", mem[64], 32'h8899_77BB);
        check("lw_after_sb_memread", {31'b0, bus.MemRead}, 32'd1);
        @(posedge clk);
        #1;
        check("lw_after_sb_valid", {31'b0, bus.resp_valid}, 32'd1);
        check("lw_after_sb_data", bus.resp_data, 32'h8899_77BB);

        // Misaligned and illegal requests
        err_op("sh101", 1'b1, F3_H, 32'h101);
        err_op("lw102", 1'b0, F3_W, 32'h102);
        err_op("ld011", 1'b0, 3'b011, 32'h100);
        check("err_mem", mem[64], 32'h8899_77BB);

        // SW then LW accepted in the SW response cycle
        @(negedge clk);
        req(1'b1, 1'b1, F3_W, 32'h104, 32'hDEAD_BEEF);
        #1;
        check("sw_memwrite", {31'b0, bus.MemWrite}, 32'd1);
        check("sw_memread", {31'b0, bus.MemRead}, 32'd0);
        check("sw_wdata", bus.write_data, 32'hDEAD_BEEF);
        check("sw_addr", bus.data_addr, 32'h104);
        @(posedge clk);
        #1;
        check("sw_valid", {31'b0, bus.resp_valid}, 32'd1);
        check("sw_data", bus.resp_data, 32'h0);
        load_op("lw104", F3_W, 32'h104, 32'hDEAD_BEEF);

        // Reset while the RMW write is pending
        @(negedge clk);
        req(1'b1, 1'b1, F3_B, 32'h100, 32'h0000_0055);
        #1;
        check("sb2_memread", {31'b0, bus.MemRead}, 32'd1);
        @(posedge clk);
        #1;
        check("sb2_rmw_memwrite", {31'b0, bus.MemWrite}, 32'd1);
        @(negedge clk);
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        check("rst_rmw_memwrite", {31'b0, bus.MemWrite}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_rmw_mem", mem[64], 32'h8899_77BB);
        check("rst_rmw_valid", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_rmw_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_rmw_valid2", {31'b0, bus.resp_valid}, 32'd0);

        // Reset during an accept cycle captures nothing
        @(negedge clk);
        req(1'b1, 1'b0, F3_W, 32'h100, 32'h0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_acc_valid", {31'b0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_acc_valid2", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_acc_data", bus.resp_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
